onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port on-chip RAM among NUM_REQ Avalon-MM masters (one per NIOS processing core in the image pipeline).
- The RAM is 75000 x 32-bit with byte enables, registered address and unregistered output, so read latency is 1 cycle.
- The block grants at most one access per cycle, drives the RAM port, and routes read data back to the granted requester with readdatavalid.
- It sits between the per-core data masters and the shared image buffer RAM.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ADDR_W, 17, word address width.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_address  in  NUM_REQ*ADDR_W  packed word addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_byteenable  in  NUM_REQ*BE_W  packed byte enables.
- req_read  in  NUM_REQ  read strobes.
- req_write  in  NUM_REQ  write strobes.
- req_writedata  in  NUM_REQ*DATA_W  packed write data.
- req_waitrequest  out  NUM_REQ  per-requester stall.
- req_readdata  out  DATA_W  read data, shared by all requesters.
- req_readdatavalid  out  NUM_REQ  one-hot; marks the cycle req_readdata is valid for requester i.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  BE_W  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  DATA_W  RAM output; valid 1 cycle after a read is issued.

Behaviour:
- Active requester i: req_read[i] | req_write[i]. If both are set, the access is treated as a write and no read data is returned.
- Arbitration is combinational each cycle and uses a registered pointer rr_ptr.
  - Winner is the first active requester at or after rr_ptr, searching upward and wrapping from NUM_REQ-1 to 0.
  - No active requester means no grant.
- Winner's handshake:
  - req_waitrequest[winner] = 0 in the same cycle, so the access is accepted at that clock edge.
  - All other requesters: req_waitrequest = 1.
  - Zero-wait acceptance is possible when the winner is alone.
- Granted cycle, RAM side:
  - mem_chipselect = 1.
  - mem_write = winner's req_write.
  - mem_address, mem_byteenable and mem_writedata are muxed from the winner.
- No grant, RAM side: mem_chipselect = 0 and mem_write = 0. Address, byteenable and writedata hold the requester-0 mux value (don't care).
- rr_ptr update at the edge of a granted cycle: rr_ptr <= (winner+1) mod NUM_REQ. It is unchanged when there is no grant.
- Read return pipeline:
  - When the granted access is a read, the block registers rd_pend = 1 and rd_id = winner.
  - Next cycle: req_readdatavalid[rd_id] = 1 and req_readdata = mem_readdata. All other readdatavalid bits are 0.
  - Latency from acceptance to data is exactly 1 cycle.
  - One read can be accepted per cycle, back-to-back, with no bubbles.
- Writes: no response signal; data is in the RAM one cycle after acceptance.
- Requester obligation: hold address, data and strobes stable while its waitrequest is 1 (Avalon rule). The arbiter does not latch requests.
- Reset (synchronous):
  - rr_ptr = 0, rd_pend = 0, rd_id = 0.
  - While reset = 1: all req_waitrequest = 1, mem_chipselect = 0, mem_write = 0, req_readdatavalid = 0.
  - req_readdata follows mem_readdata (don't care when invalid).
  - A read accepted in the cycle before reset asserts is dropped: no readdatavalid after reset.
- Out-of-range addresses (>= 75000) pass through unchecked; the result is RAM-defined.
- Starvation bound: any continuously active requester is granted within NUM_REQ cycles.

Decomposition:
- Package mem_arb_pkg holds:
  - constants MEM_ADDR_W=17, MEM_DATA_W=32, MEM_BE_W=4, MEM_DEPTH=75000, MEM_RD_LAT=1;
  - a function rr_pick(active, ptr) returning the winner index and a valid flag.
- Sub-module rr_arbiter (parameter N) contains the pointer register, wrap-around priority search, and outputs grant_onehot, grant_idx and grant_valid.
- The top level contains the muxes, the read-return pipeline and the handshake logic.

Test Plan:
- Requester 0 writes 0xDEADBEEF to 0x00010 with BE=0xF, then reads 0x00010 -> both accepted with waitrequest=0; req_readdatavalid = 4'b0001 exactly 1 cycle after the read, with readdata 0xDEADBEEF.
- All 4 requesters read distinct preloaded addresses simultaneously after reset -> grant order 0,1,2,3 on consecutive cycles; readdatavalid one-hot 0001,0010,0100,1000 with matching data; requester i sees waitrequest for i cycles.
- Write 0xFFFFFFFF to 0x00020, then write 0x11223344 with BE=0x5, then read -> 0xFF22FF44.
- Only requesters 3 and 0 active continuously -> grants alternate 3,0,3,0 (pointer wrap); one acceptance per cycle; readdatavalid routed to the matching id with no bubbles.
- Requester 1 read accepted at cycle t, reset asserted at t+1 -> no readdatavalid at t+1 or later; during reset all waitrequest=1 and mem_chipselect=0; first post-reset grant with all active goes to requester 0.
- Requester 2 asserts read and write together with writedata 0xA5A5A5A5 -> treated as a write (mem_write=1), no readdatavalid; a subsequent read returns 0xA5A5A5A5.

Source files
------------

// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for the on-chip RAM arbiter.
// rr_pick works on up to RR_MAX requesters; callers zero-extend their request vector.
package mem_arb_pkg;

   localparam int          MEM_ADDR_W = 17;
   localparam int          MEM_DATA_W = 32;
   localparam int          MEM_BE_W   = 4;
   localparam int          MEM_DEPTH  = 75000;
   localparam int          MEM_RD_LAT = 1;
   localparam int unsigned RR_MAX     = 8;
   localparam int          RR_IDX_W   = 3;

   typedef struct packed {
      logic                valid;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First active index at or above ptr, wrapping at n; n must be <= RR_MAX and ptr < n.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   active,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int unsigned         n);
      rr_pick_t    r;
      int unsigned cand;
      r = '0;
      for (int unsigned k = 0; k < RR_MAX; k++) begin
         cand = 32'(ptr) + k;
         if (cand >= n) cand = cand - n;
         if (k < n && !r.valid && active[cand[RR_IDX_W-1:0]]) begin
            r.valid = 1'b1;
            r.idx   = cand[RR_IDX_W-1:0];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/onchip_mem_arbiter_rr.sv
// Round-robin arbiter: combinational grant from a registered pointer, zero latency.
// No backpressure of its own; the pointer moves past the winner only on a grant.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     active,
   output logic [N-1:0]     grant_onehot,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0]  rr_ptr;
   logic [RR_MAX-1:0] active_ext;
   rr_pick_t          pick;

   always_comb begin
      active_ext        = '0;
      active_ext[N-1:0] = active;
      pick              = rr_pick(active_ext, RR_IDX_W'(rr_ptr), N);
   end

   assign grant_valid = pick.valid;
   assign grant_idx   = IDX_W'(pick.idx);

   always_comb begin
      grant_onehot = '0;
      if (pick.valid) grant_onehot[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (grant_valid) begin
         rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM among NUM_REQ Avalon-MM masters; read data returns 1 cycle after acceptance.
// Losers are held off with waitrequest; requests are never latched, so masters must hold them stable.
module onchip_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int BE_W    = MEM_BE_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
   input  logic [NUM_REQ-1:0]        req_read,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
   output logic [NUM_REQ-1:0]        req_waitrequest,
   output logic [DATA_W-1:0]         req_readdata,
   output logic [NUM_REQ-1:0]        req_readdatavalid,
   output logic [ADDR_W-1:0]         mem_address,
   output logic [BE_W-1:0]           mem_byteenable,
   output logic                      mem_chipselect,
   output logic                      mem_write,
   output logic [DATA_W-1:0]         mem_writedata,
   output logic                      mem_clken,
   input  logic [DATA_W-1:0]         mem_readdata
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] active;
   logic [NUM_REQ-1:0] grant_onehot;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_valid;
   logic               granted;
   logic [IDX_W-1:0]   sel;
   logic               rd_accept;
   logic               rd_pend;
   logic [IDX_W-1:0]   rd_id;

   assign active = req_read | req_write;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk          (clk),
      .reset        (reset),
      .active       (active),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid)
   );

   // Reset masks the grant here so nothing reaches the RAM or a master during reset.
   assign granted = grant_valid & ~reset;
   assign sel     = grant_valid ? grant_idx : '0;

   assign mem_address     = req_address[sel*ADDR_W +: ADDR_W];
   assign mem_byteenable  = req_byteenable[sel*BE_W +: BE_W];
   assign mem_writedata   = req_writedata[sel*DATA_W +: DATA_W];
   assign mem_chipselect  = granted;
   assign mem_write       = granted & req_write[sel];
   assign mem_clken       = 1'b1;
   assign req_waitrequest = ~(grant_onehot & {NUM_REQ{granted}});

   // Read+write together is a write and earns no read response.
   assign rd_accept = granted & req_read[sel] & ~req_write[sel];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rd_id   <= '0;
      end else begin
         rd_pend <= rd_accept;
         if (rd_accept) rd_id <= sel;
      end
   end

   assign req_readdata = mem_readdata;

   always_comb begin
      req_readdatavalid = '0;
      if (rd_pend && !reset) req_readdatavalid[rd_id] = 1'b1;
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural RAM, a shadow memory and a read scoreboard.
module tb_onchip_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int N  = 4;
   localparam int AW = MEM_ADDR_W;
   localparam int DW = MEM_DATA_W;
   localparam int BW = MEM_BE_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [N*AW-1:0]   req_address;
   logic [N*BW-1:0]   req_byteenable;
   logic [N-1:0]      req_read;
   logic [N-1:0]      req_write;
   logic [N*DW-1:0]   req_writedata;
   logic [N-1:0]      req_waitrequest;
   logic [DW-1:0]     req_readdata;
   logic [N-1:0]      req_readdatavalid;
   logic [AW-1:0]     mem_address;
   logic [BW-1:0]     mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DW-1:0]     mem_writedata;
   logic              mem_clken;
   logic [DW-1:0]     mem_readdata;

   onchip_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_address       (req_address),
      .req_byteenable    (req_byteenable),
      .req_read          (req_read),
      .req_write         (req_write),
      .req_writedata     (req_writedata),
      .req_waitrequest   (req_waitrequest),
      .req_readdata      (req_readdata),
      .req_readdatavalid (req_readdatavalid),
      .mem_address       (mem_address),
      .mem_byteenable    (mem_byteenable),
      .mem_chipselect    (mem_chipselect),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_clken         (mem_clken),
      .mem_readdata      (mem_readdata)
   );

   // Per-requester stimulus, packed onto the DUT buses.
   logic [N-1:0]  rd;
   logic [N-1:0]  wr;
   logic [AW-1:0] addr [N];
   logic [BW-1:0] be   [N];
   logic [DW-1:0] wd   [N];

   assign req_read  = rd;
   assign req_write = wr;

   always_comb begin
      req_address    = '0;
      req_byteenable = '0;
      req_writedata  = '0;
      for (int i = 0; i < N; i++) begin
         req_address[i*AW +: AW]    = addr[i];
         req_byteenable[i*BW +: BW] = be[i];
         req_writedata[i*DW +: DW]  = wd[i];
      end
   end

   function automatic logic [DW-1:0] preload(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   // RAM: registered address, unregistered output, byte-enable writes.
   logic [DW-1:0] ram [0:MEM_DEPTH-1];
   logic [AW-1:0] ram_addr_q;
   assign mem_readdata = ram[ram_addr_q];

   initial begin
      logic [AW-1:0] pa;
      ram_addr_q = '0;
      for (int a = 0; a < MEM_DEPTH; a++) ram[a] = '0;
      for (int i = 0; i < 4; i++) begin
         pa = AW'(64 + i);
         ram[pa] = preload(i);
      end
      forever begin
         @(posedge clk);
         if (mem_chipselect && mem_clken) begin
            if (mem_write)
               for (int b = 0; b < BW; b++)
                  if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] = mem_writedata[b*8 +: 8];
            ram_addr_q = mem_address;
         end
      end
   end

   typedef struct {
      int            id;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb [$];
   exp_t          mon_e;
   logic [DW-1:0] shadow [0:255];
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_all();
      rd = '0;
      wr = '0;
      for (int i = 0; i < N; i++) begin
         addr[i] = '0;
         be[i]   = '0;
         wd[i]   = '0;
      end
   endtask

   task automatic set_req(input int i, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [BW-1:0] b, input logic [DW-1:0] d);
      rd[i]   = r;
      wr[i]   = w;
      addr[i] = a;
      be[i]   = b;
      wd[i]   = d;
   endtask

   // One clock: check handshake/RAM side at the negedge, record the expected outcome of the
   // intended winner in the shadow memory / scoreboard, then step past the rising edge.
   task automatic cycle(input logic [3:0] exp_wait, input logic [3:0] exp_rdv,
                        input logic [DW-1:0] exp_data, input bit push_en, input string tag);
      int   w = -1;
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < N; i++) if (!exp_wait[i]) w = i;
      chk({tag, ":wait"}, 64'(req_waitrequest), 64'(exp_wait));
      chk({tag, ":rdv"}, 64'(req_readdatavalid), 64'(exp_rdv));
      if (exp_rdv != 4'b0000) chk({tag, ":rdata"}, 64'(req_readdata), 64'(exp_data));
      chk({tag, ":cs"}, 64'(mem_chipselect), 64'(w >= 0));
      chk({tag, ":mwr"}, 64'(mem_write), 64'((w >= 0) ? wr[w] : 1'b0));
      if (w >= 0) begin
         chk({tag, ":maddr"}, 64'(mem_address), 64'(addr[w]));
         if (wr[w]) begin
            chk({tag, ":mwdata"}, 64'(mem_writedata), 64'(wd[w]));
            chk({tag, ":mbe"}, 64'(mem_byteenable), 64'(be[w]));
            for (int b = 0; b < BW; b++)
               if (be[w][b]) shadow[addr[w][7:0]][b*8 +: 8] = wd[w][b*8 +: 8];
         end else if (rd[w] && push_en) begin
            e.id   = w;
            e.data = shadow[addr[w][7:0]];
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Every read response is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (|req_readdatavalid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rdv", 64'(req_readdatavalid), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_rdv_id", 64'(req_readdatavalid), 64'(4'b0001 << mon_e.id));
            chk("sb_rdata", 64'(req_readdata), 64'(mon_e.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clr_all();
      for (int a = 0; a < 256; a++) shadow[a] = '0;
      for (int i = 0; i < 4; i++) shadow[64 + i] = preload(i);
      @(posedge clk);
      #1;

      // Reset holds everyone off even with a request pending.
      set_req(0, 1'b1, 1'b0, 17'h00010, 4'hF, 32'h0);
      cycle(4'b1111, 4'b0000, '0, 1'b0, "rst_a");
      cycle(4'b1111, 4'b0000, '0, 1'b0, "rst_b");
      reset = 1'b0;

      // Single requester write then read-back.
      set_req(0, 1'b0, 1'b1, 17'h00010, 4'hF, 32'hDEADBEEF);
      cycle(4'b1110, 4'b0000, '0, 1'b1, "t1_wr");
      set_req(0, 1'b1, 1'b0, 17'h00010, 4'hF, 32'h0);
      cycle(4'b1110, 4'b0000, '0, 1'b1, "t1_rd");
      clr_all();
      cycle(4'b1111, 4'b0001, 32'hDEADBEEF, 1'b1, "t1_ret");

      // Fresh pointer: all four read at once, served 0,1,2,3 back to back.
      reset = 1'b1;
      cycle(4'b1111, 4'b0000, '0, 1'b0, "t2_rst");
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(64 + i), 4'hF, 32'h0);
      for (int i = 0; i < N; i++) begin
         cycle(4'(~(4'b0001 << i)), (i == 0) ? 4'b0000 : 4'(4'b0001 << (i - 1)),
               preload(i - 1), 1'b1, "t2_rr");
         rd[i] = 1'b0;
      end
      cycle(4'b1111, 4'b1000, preload(3), 1'b1, "t2_ret");

      // Byte-enable merge.
      set_req(1, 1'b0, 1'b1, 17'h00020, 4'hF, 32'hFFFFFFFF);
      cycle(4'b1101, 4'b0000, '0, 1'b1, "t3_wr_full");
      set_req(1, 1'b0, 1'b1, 17'h00020, 4'h5, 32'h11223344);
      cycle(4'b1101, 4'b0000, '0, 1'b1, "t3_wr_be5");
      set_req(1, 1'b1, 1'b0, 17'h00020, 4'hF, 32'h0);
      cycle(4'b1101, 4'b0000, '0, 1'b1, "t3_rd");
      clr_all();
      cycle(4'b1111, 4'b0010, 32'hFF22FF44, 1'b1, "t3_ret");

      // Requesters 3 and 0 alternate across the wrap with no response bubbles.
      set_req(3, 1'b1, 1'b0, 17'h00043, 4'hF, 32'h0);
      set_req(0, 1'b1, 1'b0, 17'h00040, 4'hF, 32'h0);
      cycle(4'b0111, 4'b0000, '0, 1'b1, "t4_g3a");
      cycle(4'b1110, 4'b1000, preload(3), 1'b1, "t4_g0a");
      cycle(4'b0111, 4'b0001, preload(0), 1'b1, "t4_g3b");
      cycle(4'b1110, 4'b1000, preload(3), 1'b1, "t4_g0b");
      clr_all();
      cycle(4'b1111, 4'b0001, preload(0), 1'b1, "t4_ret");

      // A read accepted just before reset must never be answered.
      set_req(1, 1'b1, 1'b0, 17'h00041, 4'hF, 32'h0);
      cycle(4'b1101, 4'b0000, '0, 1'b0, "t5_acc");
      reset = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(64 + i), 4'hF, 32'h0);
      cycle(4'b1111, 4'b0000, '0, 1'b0, "t5_rst_a");
      cycle(4'b1111, 4'b0000, '0, 1'b0, "t5_rst_b");
      reset = 1'b0;
      cycle(4'b1110, 4'b0000, '0, 1'b1, "t5_first");
      clr_all();
      cycle(4'b1111, 4'b0001, preload(0), 1'b1, "t5_ret");

      // Read and write together behave as a write only.
      set_req(2, 1'b1, 1'b1, 17'h00030, 4'hF, 32'hA5A5A5A5);
      cycle(4'b1011, 4'b0000, '0, 1'b1, "t6_rw");
      set_req(2, 1'b1, 1'b0, 17'h00030, 4'hF, 32'h0);
      cycle(4'b1011, 4'b0000, '0, 1'b1, "t6_rd");
      clr_all();
      cycle(4'b1111, 4'b0100, 32'hA5A5A5A5, 1'b1, "t6_ret");
      cycle(4'b1111, 4'b0000, '0, 1'b1, "t6_quiet");

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
